keypad_scan: RTL and testbench
==============================

# keypad_scan

Scanned-matrix input block for a 4x4 keypad, the input-side counterpart of the multiplexed seven-segment display driver on the same board I/O. It drives one row low at a time and samples the four column inputs. It debounces the full 16-key image over whole scan frames and delivers single-key press events through a one-entry valid/ready buffer to the CPU I/O bus. A live "key held" level is also exposed.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each row is driven (dwell); must be >= 2.
- `DEBOUNCE`, default 4: number of consecutive identical frame snapshots required to accept a new key image; must be >= 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `row_out`  out  4  row drive, active-low, one-cold.
- `col_in`  in  4  column sense, active-low (pulled up externally, already synchronised upstream).
- `key_valid`  out  1  buffered press event available.
- `key_code`  out  4  code of buffered event = row*4 + col.
- `key_ready`  in  1  consumer accepts event when high with `key_valid`.
- `key_held`  out  1  debounced image has at least one key down.
- `overflow`  out  1  sticky: an event was dropped because the buffer was full.

## Operation
- Dwell counter `div` counts 0..SCAN_DIV-1 and wraps; row index `r` (2 bits) advances by 1 (3 wraps to 0) on the cycle after `div == SCAN_DIV-1`.
- `row_out = ~(1 << r)`.
- Sampling: when `div == SCAN_DIV-1`, `~col_in` is written into bits `[r*4 +: 4]` of the 16-bit frame image. A 1 bit means the key is pressed. Only that last dwell cycle is sampled, which allows row settling.
- Frame end: the sample cycle with `r == 3`. At frame end the completed image `snap` is compared with the previous frame image `prev`:
  - If `snap == prev`: `stable` increments, saturating at DEBOUNCE.
  - Otherwise `stable <= 1`.
  - In both cases `prev <= snap`.
- Accept: when the updated `stable` equals DEBOUNCE and `snap != deb`, `deb <= snap`. Here `deb` is the debounced image, reset 0.
- Press detection on each `deb` update:
  - Event fires only if the old `deb == 0` and the new `deb` has exactly one bit set. The code is that bit's index.
  - Multi-key images, or a second key added while one is held, produce no event.
  - Releases produce no event.
  - A new event needs `deb` to return to 0 first.
- `key_held = |deb`.
- Buffer, one entry:
  - Event with buffer empty, or being drained this cycle (`key_valid && key_ready`): load `key_code`; `key_valid` goes or stays 1.
  - Event with buffer full and not draining: event dropped; `overflow <= 1` until `rst`.
  - Drain with no event: `key_valid <= 0`. `key_code` holds its last value.
- Reset clears everything: `div`, `r`, the frame image, `prev`, `stable`, `deb`, and the buffer. A reset mid-frame discards the partial image, and scanning restarts at row 0.

## Timing
- Reset values: `row_out = 4'b1110`, `key_valid = 0`, `key_code = 0`, `key_held = 0`, `overflow = 0`.
- Frame length F = 4*SCAN_DIV cycles. First frame end occurs 4*SCAN_DIV-1 cycles after reset deasserts.
- `deb` and the event take effect in the cycle after the accepting frame end. `key_valid` and `key_held` are registered outputs visible in that cycle.
- Worst-case press-to-`key_valid` for a clean, steady press: (DEBOUNCE+1)*F + 1 cycles. The first frame may be partial.
- `key_valid` is never combinationally dependent on `key_ready`. While `key_valid = 1` and `key_ready = 0`, `key_code` is stable.
- Simultaneous event and drain: the new code is loaded, `key_valid` stays 1, and there is no overflow.

## Test plan
Use SCAN_DIV=4, DEBOUNCE=3 (F=16).
- After reset, `row_out` cycles 1110, 1101, 1011, 0111 with 4 cycles each, and outputs hold their reset values with `col_in = 4'hF`.
- Hold row 2 / col 1 pressed steadily, with `key_ready = 0` (the key model drives col_in low only while the matching row is low):
  - Single `key_valid` rises with `key_code = 9`, `key_held = 1`, within 65 cycles.
  - `key_valid` stays high; pulse `key_ready` → `key_valid = 0` next cycle.
- Bounce: toggle the row 0 / col 0 contact every 10 cycles for 100 cycles, then hold it → no event during bouncing; exactly one event with `key_code = 0` at most 3 stable frames after the hold begins.
- Press keys 5 and 6 together, release, then press key 15 → no event for the pair; event `key_code = 15` after release-to-0 then press.
- With `key_ready = 0`, deliver key 3, release, then key 7 → `key_code` stays 3, `overflow = 1`. Raise `key_ready` in the same cycle a third event (key 12) fires → `key_valid` stays 1, `key_code = 12`.
- Assert `rst` mid-frame while key 9 is held and while an event is buffered → next cycle all outputs are at reset values. After `rst` deasserts, a new event with `key_code = 9` arrives after the debounce time.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one-cold row drive, whole-frame debounce of the 16-key image,
// single-key press events delivered through a one-entry valid/ready buffer.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_out_q, row_out_d;
  logic [15:0]      frame_q, frame_d;
  logic [15:0]      prev_q, prev_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [15:0]      deb_q, deb_d;
  logic             held_q, held_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic             ovf_q, ovf_d;

  logic             sample, frame_end, accept, press, drain;
  logic [15:0]      snap;
  logic [STB_W-1:0] stable_nxt;
  logic [3:0]       press_code;

  // Scan timing and frame capture; only the last dwell cycle of a row is sampled.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (row_q == 2'd3);
    div_d     = sample ? '0 : div_q + 1'b1;
    row_d     = sample ? row_q + 2'd1 : row_q;
    row_out_d = ~(4'b0001 << row_d);
    snap      = frame_q;
    snap[{row_q, 2'b00} +: 4] = ~col_in;
    frame_d   = sample ? snap : frame_q;
  end

  // Frame-level debounce: the image must repeat DEBOUNCE frames before it is accepted.
  always_comb begin
    if (snap == prev_q)
      stable_nxt = (stable_q == STB_MAX) ? STB_MAX : stable_q + 1'b1;
    else
      stable_nxt = STB_W'(1);
    stable_d = frame_end ? stable_nxt : stable_q;
    prev_d   = frame_end ? snap : prev_q;
    accept   = frame_end && (stable_nxt == STB_MAX) && (snap != deb_q);
    deb_d    = accept ? snap : deb_q;
    held_d   = |deb_d;
  end

  // A press event needs an idle keypad followed by exactly one key.
  always_comb begin
    press      = accept && (deb_q == '0) && $onehot(snap);
    press_code = '0;
    for (int i = 0; i < 16; i++)
      if (snap[i]) press_code = 4'(i);
  end

  always_comb begin
    drain   = valid_q && key_ready;
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    if (press) begin
      if (!valid_q || drain) begin
        valid_d = 1'b1;
        code_d  = press_code;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      row_q     <= '0;
      row_out_q <= 4'b1110;
      frame_q   <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      deb_q     <= '0;
      held_q    <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      row_q     <= row_d;
      row_out_q <= row_out_d;
      frame_q   <= frame_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      deb_q     <= deb_d;
      held_q    <= held_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed bench for keypad_scan; a frame-level reference model feeds
// an expected-event queue that an independent monitor drains.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int F  = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_out, col_in;
  logic        key_valid, key_ready = 1'b0, key_held, overflow;
  logic [3:0]  key_code;
  logic [15:0] keys = '0;

  int total = 0;
  int bad   = 0;
  int shown = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow)
  );

  // Passive matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (shown < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      shown++;
    end
  endfunction

  // Reference model: time index since reset, frame images, debounce count, buffer.
  int          m_t = 0;
  logic [15:0] m_img = '0, m_prev = '0, m_deb = '0;
  int          m_stable = 0;
  logic        m_valid = 1'b0, m_ovf = 1'b0;
  logic [3:0]  m_code = '0;
  logic [3:0]  exp_q[$];
  int          ev_seen = 0;

  initial begin
    logic        c_rst, c_rdy, ev, drain;
    logic [15:0] c_keys;
    logic [3:0]  evc;
    int          row;
    forever begin
      @(posedge clk);
      c_rst = rst; c_keys = keys; c_rdy = key_ready;
      #1;
      if (c_rst) begin
        m_t = 0; m_img = '0; m_prev = '0; m_deb = '0; m_stable = 0;
        m_valid = 1'b0; m_ovf = 1'b0; m_code = '0;
      end else begin
        row   = (m_t / SD) % 4;
        ev    = 1'b0;
        evc   = '0;
        drain = m_valid && c_rdy;
        if (m_t % SD == SD - 1) begin
          m_img[row*4 +: 4] = c_keys[row*4 +: 4];
          if (row == 3) begin
            if (m_img == m_prev) m_stable = (m_stable < DB) ? m_stable + 1 : DB;
            else m_stable = 1;
            m_prev = m_img;
            if (m_stable == DB && m_img != m_deb) begin
              if (m_deb == '0 && $countones(m_img) == 1) begin
                ev = 1'b1;
                for (int i = 0; i < 16; i++) if (m_img[i]) evc = 4'(i);
              end
              m_deb = m_img;
            end
          end
        end
        if (ev) begin
          if (!m_valid || drain) begin
            m_valid = 1'b1;
            m_code  = evc;
            exp_q.push_back(evc);
          end else m_ovf = 1'b1;
        end else if (drain) m_valid = 1'b0;
        m_t++;
      end
    end
  end

  // Monitor: pops an expected code whenever the DUT loads a new buffered event.
  initial begin
    logic       r_rst, r_rdy, prev_v;
    logic [3:0] exp_code, exp_row;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      r_rst = rst; r_rdy = key_ready;
      #2;
      if (!r_rst && key_valid && (!prev_v || r_rdy)) begin
        ev_seen++;
        if (exp_q.size() == 0) check("unexpected_event", 32'(key_code), 32'hFFFF);
        else begin
          exp_code = exp_q.pop_front();
          check("event_code", 32'(key_code), 32'(exp_code));
        end
      end
      exp_row = ~(4'b0001 << ((m_t / SD) % 4));
      check("row_out", 32'(row_out), 32'(exp_row));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_code", 32'(key_code), 32'(m_code));
      check("key_held", 32'(key_held), 32'(|m_deb));
      check("overflow", 32'(overflow), 32'(m_ovf));
      prev_v = key_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (key_valid) begin ok = 1'b1; break; end
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  task automatic align(input int ph);
    for (int i = 0; i <= F; i++) begin
      if (m_t % F == ph) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_row"}, 32'(row_out), 32'hE);
    check({nm, "_valid"}, 32'(key_valid), 32'd0);
    check({nm, "_code"}, 32'(key_code), 32'd0);
    check({nm, "_held"}, 32'(key_held), 32'd0);
    check({nm, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [3:0] er;
    int n0, t0, k;
    cyc(3);
    check_reset_outs("reset");
    rst = 1'b0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      er = ~(4'b0001 << (((i + 1) / SD) % 4));
      check("row_seq", 32'(row_out), 32'(er));
      check("idle_valid", 32'(key_valid), 32'd0);
    end

    // Steady key 9 with no consumer, then a single ready pulse.
    keys[9] = 1'b1;
    wait_valid("key9_timeout", (DB + 1) * F + 1);
    check("key9_code", 32'(key_code), 32'd9);
    check("key9_held", 32'(key_held), 32'd1);
    cyc(10);
    check("key9_stays", 32'(key_valid), 32'd1);
    pulse_ready();
    check("key9_drained", 32'(key_valid), 32'd0);
    keys = '0;
    cyc(80);

    // Bouncing contact, frame-aligned so no image repeats long enough.
    align(0);
    n0 = ev_seen;
    for (int b = 0; b < 10; b++) begin
      keys[0] = (b % 2 == 0);
      cyc(10);
    end
    keys[0] = 1'b1;
    check("bounce_no_event", 32'(ev_seen), 32'(n0));
    wait_valid("bounce_timeout", 3 * F + 1 + F);
    check("bounce_code", 32'(key_code), 32'd0);
    pulse_ready();
    keys = '0;
    cyc(80);

    // Two keys together never produce an event.
    n0 = ev_seen;
    keys[5] = 1'b1; keys[6] = 1'b1;
    cyc(80);
    check("pair_held", 32'(key_held), 32'd1);
    check("pair_no_event", 32'(ev_seen), 32'(n0));
    keys = '0;
    cyc(80);
    check("pair_released", 32'(key_held), 32'd0);
    keys[15] = 1'b1;
    wait_valid("key15_timeout", (DB + 1) * F + 1);
    check("key15_code", 32'(key_code), 32'd15);
    pulse_ready();
    keys = '0;
    cyc(80);

    // Full buffer drops key 7; key 12 lands on the same edge as a drain.
    keys[3] = 1'b1;
    wait_valid("key3_timeout", (DB + 1) * F + 1);
    keys = '0;
    cyc(80);
    keys[7] = 1'b1;
    cyc(80);
    check("ovf_code", 32'(key_code), 32'd3);
    check("ovf_flag", 32'(overflow), 32'd1);
    keys = '0;
    cyc(80);
    align(0);
    t0 = m_t;
    keys[12] = 1'b1;
    for (int i = 0; i < 4 * F; i++) begin
      if (m_t == t0 + 3 * F - 1) break;
      @(negedge clk);
    end
    pulse_ready();
    check("swap_valid", 32'(key_valid), 32'd1);
    check("swap_code", 32'(key_code), 32'd12);
    check("swap_ovf", 32'(overflow), 32'd1);

    // Reset mid-frame with key 9 held and an event buffered.
    keys = '0;
    cyc(80);
    keys[9] = 1'b1;
    cyc(80);
    check("pre_rst_held", 32'(key_held), 32'd1);
    align(7);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("midrst");
    rst = 1'b0;
    wait_valid("post_rst_timeout", (DB + 1) * F + 1);
    check("post_rst_code", 32'(key_code), 32'd9);
    pulse_ready();
    keys = '0;
    cyc(80);

    // Random key patterns, random consumer, occasional resets.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      k = $urandom_range(0, 9);
      if (k < 5) keys = '0;
      else if (k < 8) keys = 16'h0001 << $urandom_range(0, 15);
      else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      for (int d = 0; d < int'($urandom_range(20, 140)); d++) begin
        key_ready = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    keys = '0;
    key_ready = 1'b1;
    cyc(100);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
